// File: rtl/axis_mlp_pkg.sv
// Shared types for the MLP AXI-Stream input path: FIFO entry, read FSM states, pointer sizing.
// The entry data field width is MLP_DATA_W; keep C_S_AXIS_TDATA_WIDTH equal to it.
package axis_mlp_pkg;

  localparam int unsigned MLP_DATA_W = 32;

  typedef struct packed {
    logic                  last;
    logic [MLP_DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE,
    RELEASE
  } rd_state_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous FIFO with a combinational head, extra wrap bit on both pointers,
// and occupancy derived from the pointer difference.
module axis_sync_fifo
  import axis_mlp_pkg::*;
#(
  parameter int unsigned C_WIDTH = 33,
  parameter int unsigned C_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [C_WIDTH-1:0]          wr_data,
  output logic [C_WIDTH-1:0]          rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [ptr_width(C_DEPTH):0] count
);

  localparam int unsigned AW = ptr_width(C_DEPTH);

  logic [C_WIDTH-1:0] mem [C_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Same index with differing wrap bits means the writer is a full lap ahead.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axis_slave_mlp_in.sv
// AXI-Stream slave buffering input feature words and serving them to the MLP via request/done.
// Optional TLAST/frame-length checker enabled by defining AXIS_SLAVE_FRAME_CHECK_EN.
module axis_slave_mlp_in
  import axis_mlp_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = MLP_DATA_W,
  parameter int unsigned C_FIFO_DEPTH         = 16,
  parameter int unsigned C_FRAME_LEN          = 784
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  input  logic                              pi_read_from_fifo,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   po_mlp_data,
  output logic                              po_rd_fifo_done,
  output logic                              po_mlp_last,
  output logic [$clog2(C_FIFO_DEPTH):0]     po_fifo_count
`ifdef AXIS_SLAVE_FRAME_CHECK_EN
  ,
  output logic                              po_frame_err
`endif
);

  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  rd_state_t   state;

  assign S_AXIS_TREADY = !fifo_full && !S_AXIS_ARESET;
  assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop           = (state == IDLE) && pi_read_from_fifo && !fifo_empty;
  assign wr_entry      = '{last: S_AXIS_TLAST, data: S_AXIS_TDATA};

  axis_sync_fifo #(
    .C_WIDTH ($bits(fifo_entry_t)),
    .C_DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (S_AXIS_ACLK),
    .rst     (S_AXIS_ARESET),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (po_fifo_count)
  );

  // RELEASE blocks a second pop until the requester has dropped its level request.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state           <= IDLE;
      po_mlp_data     <= '0;
      po_mlp_last     <= 1'b0;
      po_rd_fifo_done <= 1'b0;
    end else begin
      po_rd_fifo_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            po_mlp_data     <= head.data;
            po_mlp_last     <= head.last;
            po_rd_fifo_done <= 1'b1;
            state           <= RELEASE;
          end
        end
        RELEASE: begin
          if (!pi_read_from_fifo) state <= IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_SLAVE_FRAME_CHECK_EN
  localparam int unsigned CNT_W = $clog2(C_FRAME_LEN + 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             final_beat;
  logic             unused_tstrb;

  assign final_beat   = (beat_cnt == CNT_W'(C_FRAME_LEN - 1));
  assign unused_tstrb = ^S_AXIS_TSTRB;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      beat_cnt     <= '0;
      po_frame_err <= 1'b0;
    end else if (push) begin
      if (S_AXIS_TLAST != final_beat) po_frame_err <= 1'b1;
      beat_cnt <= (S_AXIS_TLAST || final_beat) ? '0 : beat_cnt + 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^S_AXIS_TSTRB ^ (C_FRAME_LEN == 0);
`endif

endmodule

// File: tb/tb_axis_slave_mlp_in.sv
// Directed bench for axis_slave_mlp_in: table-driven basic sequence plus hand-written corner cases.
module tb_axis_slave_mlp_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;
  logic        req;
  logic [31:0] mlp_data;
  logic        done;
  logic        mlp_last;
  logic [4:0]  count;
`ifdef AXIS_SLAVE_FRAME_CHECK_EN
  logic        frame_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_slave_mlp_in #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .C_FIFO_DEPTH         (16),
    .C_FRAME_LEN          (8)
  ) dut (
    .S_AXIS_ACLK       (clk),
    .S_AXIS_ARESET     (rst),
    .S_AXIS_TVALID     (tvalid),
    .S_AXIS_TDATA      (tdata),
    .S_AXIS_TSTRB      (tstrb),
    .S_AXIS_TLAST      (tlast),
    .S_AXIS_TREADY     (tready),
    .pi_read_from_fifo (req),
    .po_mlp_data       (mlp_data),
    .po_rd_fifo_done   (done),
    .po_mlp_last       (mlp_last),
    .po_fifo_count     (count)
`ifdef AXIS_SLAVE_FRAME_CHECK_EN
    ,
    .po_frame_err      (frame_err)
`endif
  );

  typedef struct {
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        req;
    logic        exp_tready;
    logic        exp_done;
    logic [31:0] exp_data;
    logic        exp_last;
    logic [4:0]  exp_count;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    req    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] exp_d, input logic exp_l);
    bit got = 0;
    req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
    end
    chk("read_done_seen", {63'd0, got}, 64'd1);
    chk("read_data", {32'd0, mlp_data}, {32'd0, exp_d});
    chk("read_last", {63'd0, mlp_last}, {63'd0, exp_l});
    req = 1'b0;
    tick();
  endtask

  logic [32:0] sb[$];

  initial begin
    tvalid = 1'b0;
    tdata  = '0;
    tstrb  = '1;
    tlast  = 1'b0;
    req    = 1'b0;
    rst    = 1'b1;

    // Reset state
    tick();
    chk("rst_tready", {63'd0, tready}, 64'd0);
    chk("rst_count", {59'd0, count}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_data", {32'd0, mlp_data}, 64'd0);
    chk("rst_last", {63'd0, mlp_last}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", {63'd0, tready}, 64'd1);

    // Four beats in, four handshakes out
    vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 5'd1};
    vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 5'd2};
    vecs[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 5'd3};
    vecs[3]  = '{1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 5'd4};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 5'd3};
    vecs[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 1'b0, 5'd3};
    vecs[6]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 5'd2};
    vecs[7]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 1'b0, 5'd2};
    vecs[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 5'd1};
    vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b0, 5'd1};
    vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 5'd0};
    vecs[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 5'd0};
    for (int i = 0; i < 12; i++) begin
      tvalid = vecs[i].tvalid;
      tdata  = vecs[i].tdata;
      tlast  = vecs[i].tlast;
      req    = vecs[i].req;
      tick();
      chk($sformatf("vec%0d_tready", i), {63'd0, tready}, {63'd0, vecs[i].exp_tready});
      chk($sformatf("vec%0d_done", i), {63'd0, done}, {63'd0, vecs[i].exp_done});
      chk($sformatf("vec%0d_data", i), {32'd0, mlp_data}, {32'd0, vecs[i].exp_data});
      chk($sformatf("vec%0d_count", i), {59'd0, count}, {59'd0, vecs[i].exp_count});
      if (vecs[i].exp_done)
        chk($sformatf("vec%0d_last", i), {63'd0, mlp_last}, {63'd0, vecs[i].exp_last});
    end
    tvalid = 1'b0;
    req    = 1'b0;

    // Fill to full, held 17th beat, one pop frees a slot
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1;
      tdata  = 32'h1000 + i;
      tick();
      chk($sformatf("fill%0d_tready", i), {63'd0, tready}, {63'd0, (i < 15)});
    end
    chk("full_count", {59'd0, count}, 64'd16);
    tdata = 32'h2000;
    tick();
    chk("held17_count", {59'd0, count}, 64'd16);
    chk("held17_tready", {63'd0, tready}, 64'd0);
    req = 1'b1;
    tick();
    chk("full_pop_done", {63'd0, done}, 64'd1);
    chk("full_pop_data", {32'd0, mlp_data}, 64'h1000);
    chk("full_pop_count", {59'd0, count}, 64'd15);
    chk("full_pop_tready", {63'd0, tready}, 64'd1);
    req = 1'b0;
    tick();
    chk("beat17_count", {59'd0, count}, 64'd16);
    chk("beat17_tready", {63'd0, tready}, 64'd0);
    tvalid = 1'b0;
    for (int i = 1; i < 16; i++) read_word(32'h1000 + i, 1'b0);
    read_word(32'h2000, 1'b0);
    chk("drain_count", {59'd0, count}, 64'd0);

    // Request held past done pops exactly once
    do_reset();
    push_beat(32'hA1, 1'b0);
    push_beat(32'hB2, 1'b0);
    req = 1'b1;
    tick();
    chk("hold_done", {63'd0, done}, 64'd1);
    chk("hold_data", {32'd0, mlp_data}, 64'hA1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_done", i), {63'd0, done}, 64'd0);
      chk($sformatf("hold%0d_count", i), {59'd0, count}, 64'd1);
    end
    req = 1'b0;
    tick();
    chk("hold_release_done", {63'd0, done}, 64'd0);
    req = 1'b1;
    tick();
    chk("hold_second_done", {63'd0, done}, 64'd1);
    chk("hold_second_data", {32'd0, mlp_data}, 64'hB2);
    chk("hold_second_count", {59'd0, count}, 64'd0);
    req = 1'b0;
    tick();

    // Request while empty waits for data
    do_reset();
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("empty_wait%0d_done", i), {63'd0, done}, 64'd0);
    end
    tvalid = 1'b1;
    tdata  = 32'hABCD;
    tick();
    tvalid = 1'b0;
    chk("empty_accept_done", {63'd0, done}, 64'd0);
    chk("empty_accept_count", {59'd0, count}, 64'd1);
    tick();
    chk("empty_serve_done", {63'd0, done}, 64'd1);
    chk("empty_serve_data", {32'd0, mlp_data}, 64'hABCD);
    chk("empty_serve_count", {59'd0, count}, 64'd0);
    req = 1'b0;
    tick();

    // 40-beat stream with interleaved reads against a scoreboard
    do_reset();
    begin
      int  sent = 0;
      int  rcvd = 0;
      bit  accepted;
      logic [32:0] exp_e;
      for (int cyc = 0; cyc < 800 && rcvd < 40; cyc++) begin
        tvalid = (sent < 40) && ($urandom_range(0, 3) != 0);
        tdata  = 32'hC000_0000 + sent;
        tlast  = (sent == 39);
        req    = done ? 1'b0 : ($urandom_range(0, 2) != 0);
        accepted = tvalid && tready;
        tick();
        if (accepted) begin
          sb.push_back({tlast, tdata});
          sent++;
        end
        if (done) begin
          if (sb.size() == 0) begin
            chk("stream_unexpected_done", 64'd1, 64'd0);
          end else begin
            exp_e = sb.pop_front();
            chk($sformatf("stream_word%0d", rcvd), {31'd0, mlp_last, mlp_data}, {31'd0, exp_e});
          end
          rcvd++;
        end
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      req    = 1'b0;
      tick();
      chk("stream_rcvd", rcvd, 64'd40);
      chk("stream_count", {59'd0, count}, 64'd0);
    end

`ifdef AXIS_SLAVE_FRAME_CHECK_EN
    // Frame length 8: early TLAST on beat 5
    do_reset();
    for (int i = 1; i <= 4; i++) push_beat(i, 1'b0);
    chk("frame_ok_err", {63'd0, frame_err}, 64'd0);
    push_beat(32'd5, 1'b1);
    chk("frame_early_err", {63'd0, frame_err}, 64'd1);
    for (int i = 0; i < 3; i++) push_beat(i, 1'b0);
    chk("frame_sticky_err", {63'd0, frame_err}, 64'd1);
    // Beat 8 without TLAST
    do_reset();
    for (int i = 1; i <= 7; i++) push_beat(i, 1'b0);
    chk("frame_7_err", {63'd0, frame_err}, 64'd0);
    push_beat(32'd8, 1'b0);
    chk("frame_missing_last_err", {63'd0, frame_err}, 64'd1);
`endif

    // Reset mid-frame discards buffered data
    do_reset();
    push_beat(32'h51, 1'b0);
    push_beat(32'h52, 1'b0);
    req = 1'b1;
    tick();
    tvalid = 1'b1;
    tdata  = 32'h53;
    rst    = 1'b1;
    #1;
    chk("midrst_tready_comb", {63'd0, tready}, 64'd0);
    tick();
    chk("midrst_tready", {63'd0, tready}, 64'd0);
    chk("midrst_count", {59'd0, count}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_data", {32'd0, mlp_data}, 64'd0);
`ifdef AXIS_SLAVE_FRAME_CHECK_EN
    chk("midrst_err", {63'd0, frame_err}, 64'd0);
`endif
    tvalid = 1'b0;
    req    = 1'b0;
    rst    = 1'b0;
    tick();
    chk("postrst_count", {59'd0, count}, 64'd0);
    chk("postrst_tready", {63'd0, tready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
